// File: rtl/usrt_tx_ctrl_if.sv
// Host-side handshake and serial line bundle for the USRT transmit sequencer.
// The host drives the byte/parity/valid group; the controller drives everything else.
interface usrt_tx_ctrl_if;
    logic [7:0] i_Data;
    logic [1:0] i_Parity;
    logic       i_Valid;
    logic       o_Ready;
    logic       o_Tx;
    logic       o_Sclk;
    logic       o_Busy;
    logic       o_Done;

    modport master (
        output i_Data,
        output i_Parity,
        output i_Valid,
        input  o_Ready,
        input  o_Tx,
        input  o_Sclk,
        input  o_Busy,
        input  o_Done
    );

    modport slave (
        input  i_Data,
        input  i_Parity,
        input  i_Valid,
        output o_Ready,
        output o_Tx,
        output o_Sclk,
        output o_Busy,
        output o_Done
    );
endinterface

// File: rtl/usrt_tx_ctrl.sv
// USRT transmit sequencer: latches one byte plus parity mode on a valid/ready
// handshake, then shifts out start, 8 data bits LSB-first, optional parity and
// stop, each held CLKS_PER_BIT cycles with a companion serial clock that rises
// at mid-bit. Every output is a flop, so the serial pins never glitch.
module usrt_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           i_Pclk,
    input  logic           i_Rst,
    usrt_tx_ctrl_if.slave  bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Last cycle of a bit, and the cycle whose successor starts the high half of o_Sclk.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SCLK_PREP = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_q;
    logic [3:0]       last_bit_q;
    // Frame bits 1..10 still to be sent; bit 0 (start) is driven straight onto o_Tx at accept.
    logic [9:0]       frame_q;
    logic             tx_q;
    logic             sclk_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             parity_en_d;
    logic             parity_bit_d;
    logic [9:0]       frame_d;

    // Build the tail of the frame from the host inputs; used only on the accept edge.
    // Mode 01 is odd parity (~^data), 10 is even (^data), 00/11 send no parity slot.
    always_comb begin
        parity_en_d  = (bus.i_Parity == 2'b01) || (bus.i_Parity == 2'b10);
        parity_bit_d = bus.i_Parity[0] ? ~(^bus.i_Data) : (^bus.i_Data);
        frame_d      = parity_en_d ? {1'b1, parity_bit_d, bus.i_Data}
                                   : {2'b11, bus.i_Data};
    end

    // Framing FSM with all outputs registered; reset abandons any partial frame.
    always_ff @(posedge i_Pclk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            sclk_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_Valid && ready_q) begin
                        state_q    <= SHIFT;
                        frame_q    <= frame_d;
                        last_bit_q <= parity_en_d ? 4'd10 : 4'd9;
                        cnt_q      <= '0;
                        bit_q      <= '0;
                        tx_q       <= 1'b0;
                        sclk_q     <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_q == last_bit_q) begin
                            state_q <= DONE;
                            bit_q   <= '0;
                            frame_q <= '0;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            tx_q    <= frame_q[0];
                            frame_q <= {1'b1, frame_q[9:1]};
                        end
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        sclk_q <= (cnt_q >= SCLK_PREP);
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Ready = ready_q;
    assign bus.o_Tx    = tx_q;
    assign bus.o_Sclk  = sclk_q;
    assign bus.o_Busy  = busy_q;
    assign bus.o_Done  = done_q;

endmodule

// File: doc/usrt_tx_ctrl.md
Name: usrt_tx_ctrl

Overview:
Transmit sequencer for the USRT serial path. Accepts one byte plus a parity mode over a valid/ready handshake and builds the frame: start, 8 data bits LSB-first, optional parity, stop. Shifts the frame out at a programmable bit rate with a companion serial clock. Sits between the host/register interface and the serial pin, and owns framing and timing for the transmitter.

Parameters:
CLKS_PER_BIT, 16, i_Pclk cycles per serial bit; even, >= 2
HALF_BIT, CLKS_PER_BIT/2, derived (localparam), o_Sclk low/high split point

Ports:
i_Pclk  in  1  system clock, rising edge
i_Rst  in  1  asynchronous reset, active-high
i_Data  in  8  byte to transmit
i_Parity  in  2  parity mode: 00 none, 01 odd, 10 even, 11 = none
i_Valid  in  1  i_Data/i_Parity valid
o_Ready  out  1  controller can accept a byte
o_Tx  out  1  serial data line, idles high
o_Sclk  out  1  serial bit clock, idles low
o_Busy  out  1  frame in progress
o_Done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, immediate, also mid-frame): state IDLE, o_Tx=1, o_Sclk=0, o_Ready=1, o_Busy=0, o_Done=0, counters and shift register cleared. The partial frame is abandoned, with no done pulse.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: o_Ready=1, o_Tx=1. A transfer occurs on an edge with i_Valid & o_Ready. i_Data and i_Parity are latched then, and later changes to them are ignored until the next accept. The state goes to SHIFT at the same edge.
- Frame register: bit0=0 (start), bits1..8=data[0..7], then parity (if enabled), then stop=1. The length N is 11 with parity and 10 with none (modes 00 and 11).
- Odd parity bit = ~^data, so the total count of ones in data+parity is odd. Even parity bit = ^data.
- SHIFT: o_Ready=0, o_Busy=1. o_Tx = current frame bit, starting the cycle after accept (latency 1). Each bit is held exactly CLKS_PER_BIT cycles.
- Within each bit, o_Sclk=0 for the first HALF_BIT cycles and 1 for the remaining HALF_BIT cycles. The receiver samples on the rising o_Sclk.
- Cycle counter: 0..CLKS_PER_BIT-1, wraps at the end of each bit, and the bit index then increments.
- After the last cycle of bit N-1 (stop), the state goes to DONE. o_Tx is registered and glitch-free, with no combinational path from inputs.
- DONE (one cycle): o_Done=1, o_Busy=0, o_Ready=0, o_Tx=1, o_Sclk=0. The state then goes to IDLE.
- The earliest next accept is the edge ending the first IDLE cycle after DONE. Back-to-back frames are therefore separated by 1 DONE cycle plus 1 IDLE cycle of line-high.
- i_Valid asserted while not ready is ignored and is not queued. The host must hold i_Valid until it sees o_Ready.
- Total cycles from the accept edge to the o_Done pulse = N*CLKS_PER_BIT + 1.

Test Plan:
- Odd parity, 8'h03, CLKS_PER_BIT=4, i_Parity=01: o_Tx bit sequence 0,1,1,0,0,0,0,0,0,1,1. Each bit lasts 4 cycles. o_Done pulses 45 cycles after accept.
- Even parity, 8'h03 -> parity bit 0. Odd 8'h07 -> parity 0. Even 8'h07 -> parity 1. The bench checks the value sampled on each o_Sclk rise.
- Mode 00, 8'h55: 10-bit frame 0,1,0,1,0,1,0,1,0,1 with no parity slot. o_Done at 41 cycles. Mode 11 gives an identical result.
- Hold i_Valid high with a new byte 8'hA5 during a frame: it is not accepted until o_Ready rises after DONE. The first frame is unchanged, and the second frame starts one cycle after the new accept.
- Change i_Data/i_Parity mid-frame (8'h03/01 -> 8'hFF/10): the transmitted bits still match 8'h03 odd.
- Assert i_Rst at bit 5 between clock edges: o_Tx=1, o_Sclk=0, o_Busy=0 immediately, with no o_Done. After release, a fresh accept of 8'h03 produces a correct full frame.
